// File: rtl/uart_pkg.sv
// uart_pkg: register offsets, status/control bit positions and FSM encodings for uart_mmio_fifo
package uart_pkg;
    localparam logic [2:0] OFF_DATA   = 3'd0;
    localparam logic [2:0] OFF_STATUS = 3'd1;
    localparam logic [2:0] OFF_DIV_LO = 3'd2;
    localparam logic [2:0] OFF_DIV_HI = 3'd3;
    localparam logic [2:0] OFF_CTRL   = 3'd4;
    localparam int ST_RX_NEMPTY = 0;
    localparam int ST_RX_FULL   = 1;
    localparam int ST_TX_EMPTY  = 2;
    localparam int ST_TX_FULL   = 3;
    localparam int ST_RX_OVF    = 4;
    localparam int ST_FRAME_ERR = 5;
    localparam int ST_TX_BUSY   = 6;
    localparam int CTRL_RX_IE = 0;
    localparam int CTRL_TX_IE = 1;
    localparam int CTRL_LOOP  = 2;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_e;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: byte FIFO where simultaneous push and pop both take effect, even when full or empty
module sync_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  logic       pop_i,
    input  logic [7:0] din_i,
    output logic [7:0] dout_o,
    output logic       full_o,
    output logic       empty_o
);
    localparam int AW = $clog2(DEPTH);
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;
    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign do_push = push_i & (~full_o | pop_i);
    assign do_pop  = pop_i & (~empty_o | push_i);
    assign dout_o  = mem_q[rd_q];
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop) rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end
endmodule

// File: rtl/uart_mmio_fifo.sv
// uart_mmio_fifo: memory-mapped UART with TX/RX FIFOs, 16x baud divisor, sticky errors, loopback and irq
module uart_mmio_fifo
    import uart_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'hE000,
    parameter int          DEPTH     = 16,
    parameter logic [15:0] DIV_RESET = 16'd27
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr_i,
    input  logic        we_i,
    input  logic        re_i,
    input  logic [7:0]  di_i,
    output logic [7:0]  do_o,
    output logic        sel_o,
    input  logic        uart_rx_i,
    output logic        uart_tx_o,
    output logic        irq_o
);
    tx_state_e   tx_state_q;
    rx_state_e   rx_state_q;
    logic [15:0] div_q, div_eff, baud_q;
    logic [2:0]  off, ctrl_q, tx_bit_q, rx_bit_q;
    logic [3:0]  tx_cnt_q, rx_cnt_q;
    logic [7:0]  tx_sh_q, rx_sh_q, tx_dout, rx_dout, status;
    logic        tick, wr, tx_push, tx_pop, tx_last, tx_q, tx_full, tx_empty, tx_busy;
    logic        rx_pop, rx_push, rx_done, rx_full, rx_empty, rx_in, s1_q, s2_q, s3_q;
    logic        rx_ovf_q, frame_err_q, irq_q;
    assign off      = addr_i[2:0];
    assign sel_o    = (addr_i[15:3] == BASE_ADDR[15:3]) && (off <= OFF_CTRL);
    assign wr       = we_i & sel_o;
    assign tx_push  = wr && off == OFF_DATA;
    assign rx_pop   = re_i && sel_o && off == OFF_DATA;
    assign div_eff  = div_q == '0 ? 16'd1 : div_q;
    assign tick     = baud_q == div_eff - 16'd1;
    assign tx_busy  = tx_state_q != TX_IDLE;
    assign tx_last  = tick && tx_cnt_q == 4'd15;
    assign tx_pop   = !tx_empty && (tx_state_q == TX_IDLE || (tx_state_q == TX_STOP && tx_last));
    assign rx_in    = ctrl_q[CTRL_LOOP] ? tx_q : uart_rx_i;
    assign rx_done  = rx_state_q == RX_STOP && tick && rx_cnt_q == 4'd15;
    assign rx_push  = rx_done && s2_q;
    assign status   = {1'b0, tx_busy, frame_err_q, rx_ovf_q, tx_full, tx_empty, rx_full, ~rx_empty};
    assign do_o     = !sel_o ? 8'h00 :
                      off == OFF_DATA   ? (rx_empty ? 8'h00 : rx_dout) :
                      off == OFF_STATUS ? status :
                      off == OFF_DIV_LO ? div_q[7:0] :
                      off == OFF_DIV_HI ? div_q[15:8] :
                      off == OFF_CTRL   ? {5'b0, ctrl_q} : 8'h00;
    assign uart_tx_o = tx_q;
    assign irq_o     = irq_q;
    sync_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
        .clk(clk), .rst(rst), .push_i(tx_push), .pop_i(tx_pop), .din_i(di_i),
        .dout_o(tx_dout), .full_o(tx_full), .empty_o(tx_empty)
    );
    sync_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
        .clk(clk), .rst(rst), .push_i(rx_push), .pop_i(rx_pop), .din_i(rx_sh_q),
        .dout_o(rx_dout), .full_o(rx_full), .empty_o(rx_empty)
    );
    always_ff @(posedge clk) begin
        if (!rst) begin
            div_q       <= DIV_RESET;
            baud_q      <= '0;
            ctrl_q      <= '0;
            rx_ovf_q    <= 1'b0;
            frame_err_q <= 1'b0;
            irq_q       <= 1'b0;
            {s1_q, s2_q, s3_q} <= 3'b111;
        end else begin
            baud_q <= (tick || (wr && (off == OFF_DIV_LO || off == OFF_DIV_HI))) ? '0 : baud_q + 16'd1;
            if (wr && off == OFF_DIV_LO) div_q[7:0] <= di_i;
            if (wr && off == OFF_DIV_HI) div_q[15:8] <= di_i;
            if (wr && off == OFF_CTRL) ctrl_q <= di_i[2:0];
            rx_ovf_q    <= (rx_push && rx_full && !rx_pop) ||
                           (rx_ovf_q && !(wr && off == OFF_STATUS && di_i[ST_RX_OVF]));
            frame_err_q <= (rx_done && !s2_q) ||
                           (frame_err_q && !(wr && off == OFF_STATUS && di_i[ST_FRAME_ERR]));
            irq_q <= (ctrl_q[CTRL_RX_IE] && !rx_empty) || (ctrl_q[CTRL_TX_IE] && tx_empty && !tx_busy);
            {s1_q, s2_q, s3_q} <= {rx_in, s1_q, s2_q};
        end
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_state_q <= TX_IDLE;
            tx_q       <= 1'b1;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_sh_q    <= '0;
        end else begin
            if (tick) tx_cnt_q <= tx_cnt_q + 4'd1;
            if (tx_pop) begin
                tx_state_q <= TX_START;
                tx_sh_q    <= tx_dout;
                tx_q       <= 1'b0;
                tx_cnt_q   <= '0;
            end else if (tx_last) begin
                case (tx_state_q)
                    TX_START: begin
                        tx_state_q <= TX_DATA;
                        tx_q       <= tx_sh_q[0];
                        tx_bit_q   <= '0;
                    end
                    TX_DATA: begin
                        tx_sh_q  <= tx_sh_q >> 1;
                        tx_bit_q <= tx_bit_q + 3'd1;
                        tx_q     <= (tx_bit_q == 3'd7) | tx_sh_q[1];
                        if (tx_bit_q == 3'd7) tx_state_q <= TX_STOP;
                    end
                    TX_STOP: tx_state_q <= TX_IDLE;
                    default: ;
                endcase
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
        end else begin
            if (tick) rx_cnt_q <= rx_cnt_q + 4'd1;
            case (rx_state_q)
                RX_IDLE: if (s3_q && !s2_q) begin
                    rx_state_q <= RX_START;
                    rx_cnt_q   <= '0;
                end
                RX_START: if (tick && rx_cnt_q == 4'd7) begin
                    rx_state_q <= s2_q ? RX_IDLE : RX_DATA;
                    rx_cnt_q   <= '0;
                    rx_bit_q   <= '0;
                end
                RX_DATA: if (tick && rx_cnt_q == 4'd15) begin
                    rx_sh_q  <= {s2_q, rx_sh_q[7:1]};
                    rx_bit_q <= rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
                end
                RX_STOP: if (rx_done) rx_state_q <= s2_q ? RX_IDLE : RX_WAIT;
                RX_WAIT: if (s2_q) rx_state_q <= RX_IDLE;
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_mmio_fifo.sv
// tb_uart_mmio_fifo: directed scenario tasks with hand-computed expectations for uart_mmio_fifo
module tb_uart_mmio_fifo;
    localparam logic [15:0] A_DATA = 16'hE000;
    localparam logic [15:0] A_STAT = 16'hE001;
    localparam logic [15:0] A_DLO  = 16'hE002;
    localparam logic [15:0] A_DHI  = 16'hE003;
    localparam logic [15:0] A_CTRL = 16'hE004;
    localparam logic [15:0] RA [5] = '{16'hE000, 16'hE001, 16'hE002, 16'hE003, 16'hE004};
    localparam logic [7:0]  RV [5] = '{8'h00, 8'h04, 8'h1B, 8'h00, 8'h00};
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] addr = '0;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic [7:0]  di = '0;
    logic [7:0]  rdata;
    logic        sel;
    logic        uart_rx = 1'b1;
    logic        uart_tx;
    logic        irq;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    uart_mmio_fifo #(.BASE_ADDR(16'hE000), .DEPTH(4), .DIV_RESET(16'd27)) dut (
        .clk(clk), .rst(rst), .addr_i(addr), .we_i(we), .re_i(re), .di_i(di),
        .do_o(rdata), .sel_o(sel), .uart_rx_i(uart_rx), .uart_tx_o(uart_tx), .irq_o(irq)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        addr = a;
        di = d;
        we = 1'b1;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, output logic [7:0] d);
        @(negedge clk);
        addr = a;
        #1 d = rdata;
    endtask

    task automatic pop_rx(output logic [7:0] d);
        @(negedge clk);
        addr = A_DATA;
        re = 1'b1;
        #1 d = rdata;
        @(negedge clk);
        re = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        logic [9:0] f;
        f = {stop, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            uart_rx = f[i];
            repeat (15) @(negedge clk);
        end
        @(negedge clk);
        uart_rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset;
        logic [7:0] v;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        checks++;
        if (uart_tx !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b exp=1", uart_tx); end
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
        for (int i = 0; i < 5; i++) begin
            rd(RA[i], v);
            checks++;
            if (v !== RV[i]) begin failures++; $display("FAIL reset_reg%0d got=%h exp=%h", i, v, RV[i]); end
            checks++;
            if (sel !== 1'b1) begin failures++; $display("FAIL reset_sel%0d got=%b exp=1", i, sel); end
        end
        rd(16'hE005, v);
        checks++;
        if (sel !== 1'b0 || v !== 8'h00) begin failures++; $display("FAIL outside_window sel=%b do=%h exp sel=0 do=00", sel, v); end
    endtask

    task automatic test_tx_frame;
        logic [7:0] v;
        logic [7:0] b;
        logic       e;
        int         n;
        b = 8'hA5;
        wr(A_DLO, 8'h01);
        rd(A_DLO, v);
        checks++;
        if (v !== 8'h01) begin failures++; $display("FAIL div_lo_rb got=%h exp=01", v); end
        wr(A_DATA, b);
        addr = A_STAT;
        n = 0;
        while (uart_tx !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (uart_tx !== 1'b0) begin failures++; $display("FAIL tx_start_timeout got=%b exp=0", uart_tx); end
        for (int i = 0; i < 160; i++) begin
            e = (i < 16) ? 1'b0 : (i < 144) ? b[(i-16)/16] : 1'b1;
            checks++;
            if (uart_tx !== e) begin failures++; $display("FAIL tx_bit clk=%0d got=%b exp=%b", i, uart_tx, e); end
            checks++;
            if (rdata[6] !== 1'b1) begin failures++; $display("FAIL tx_busy clk=%0d got=%b exp=1", i, rdata[6]); end
            @(negedge clk);
        end
        checks++;
        if (uart_tx !== 1'b1 || rdata !== 8'h04) begin failures++; $display("FAIL tx_end tx=%b status=%h exp tx=1 status=04", uart_tx, rdata); end
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] v;
        wr(A_DATA, 8'h5A);
        wr(A_DATA, 8'h3C);
        repeat (40) @(negedge clk);
        rst = 1'b0;
        addr = A_STAT;
        @(negedge clk);
        checks++;
        if (uart_tx !== 1'b1 || rdata !== 8'h04) begin failures++; $display("FAIL mid_reset tx=%b status=%h exp tx=1 status=04", uart_tx, rdata); end
        rst = 1'b1;
        rd(A_DLO, v);
        checks++;
        if (v !== 8'h1B) begin failures++; $display("FAIL mid_reset_div got=%h exp=1b", v); end
        wr(A_DLO, 8'h01);
        repeat (20) @(negedge clk);
        rd(A_STAT, v);
        checks++;
        if (v !== 8'h04 || uart_tx !== 1'b1) begin failures++; $display("FAIL mid_reset_flush status=%h tx=%b exp 04/1", v, uart_tx); end
    endtask

    task automatic test_loopback;
        logic [7:0] v;
        logic [7:0] exp_b [3];
        int c0, n;
        exp_b = '{8'h11, 8'h22, 8'h33};
        wr(A_CTRL, 8'h04);
        @(negedge clk);
        c0 = cyc;
        addr = A_DATA;
        we = 1'b1;
        for (int i = 0; i < 3; i++) begin
            di = exp_b[i];
            @(negedge clk);
        end
        we = 1'b0;
        addr = A_STAT;
        n = 0;
        #1;
        while (rdata[6] === 1'b1 && n < 2000) begin
            @(negedge clk);
            #1 n++;
        end
        checks++;
        if (cyc - c0 !== 482) begin failures++; $display("FAIL loop_b2b_len got=%0d exp=482", cyc - c0); end
        repeat (20) @(negedge clk);
        rd(A_STAT, v);
        checks++;
        if (v !== 8'h05) begin failures++; $display("FAIL loop_status got=%h exp=05", v); end
        wr(A_CTRL, 8'h01);
        @(negedge clk);
        checks++;
        if (irq !== 1'b1) begin failures++; $display("FAIL rx_irq_set got=%b exp=1", irq); end
        for (int i = 0; i < 3; i++) begin
            pop_rx(v);
            checks++;
            if (v !== exp_b[i]) begin failures++; $display("FAIL loop_data%0d got=%h exp=%h", i, v, exp_b[i]); end
        end
        @(negedge clk);
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL rx_irq_clr got=%b exp=0", irq); end
        rd(A_STAT, v);
        checks++;
        if (v !== 8'h04) begin failures++; $display("FAIL loop_drained got=%h exp=04", v); end
        wr(A_CTRL, 8'h00);
    endtask

    task automatic test_rx_overflow;
        logic [7:0] v;
        logic [7:0] fb [5];
        fb = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};
        for (int i = 0; i < 5; i++) send_frame(fb[i], 1'b1);
        rd(A_STAT, v);
        checks++;
        if (v !== 8'h17) begin failures++; $display("FAIL ovf_status got=%h exp=17", v); end
        for (int i = 0; i < 4; i++) begin
            pop_rx(v);
            checks++;
            if (v !== fb[i]) begin failures++; $display("FAIL ovf_data%0d got=%h exp=%h", i, v, fb[i]); end
        end
        rd(A_STAT, v);
        checks++;
        if (v !== 8'h14) begin failures++; $display("FAIL ovf_sticky got=%h exp=14", v); end
        wr(A_STAT, 8'h10);
        rd(A_STAT, v);
        checks++;
        if (v !== 8'h04) begin failures++; $display("FAIL ovf_clear got=%h exp=04", v); end
    endtask

    task automatic test_frame_glitch;
        logic [7:0] v;
        send_frame(8'h5A, 1'b0);
        rd(A_STAT, v);
        checks++;
        if (v !== 8'h24) begin failures++; $display("FAIL frame_err_status got=%h exp=24", v); end
        rd(A_DATA, v);
        checks++;
        if (v !== 8'h00) begin failures++; $display("FAIL frame_err_data got=%h exp=00", v); end
        wr(A_STAT, 8'h20);
        rd(A_STAT, v);
        checks++;
        if (v !== 8'h04) begin failures++; $display("FAIL frame_err_clear got=%h exp=04", v); end
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (3) @(negedge clk);
        uart_rx = 1'b1;
        repeat (40) @(negedge clk);
        rd(A_STAT, v);
        checks++;
        if (v !== 8'h04) begin failures++; $display("FAIL glitch_status got=%h exp=04", v); end
    endtask

    task automatic test_tx_full_irq;
        int c0, n;
        wr(A_CTRL, 8'h02);
        @(negedge clk);
        checks++;
        if (irq !== 1'b1) begin failures++; $display("FAIL tx_irq_idle got=%b exp=1", irq); end
        @(negedge clk);
        c0 = cyc;
        addr = A_DATA;
        we = 1'b1;
        for (int i = 0; i < 6; i++) begin
            di = 8'h40 + 8'(i);
            @(negedge clk);
        end
        we = 1'b0;
        addr = A_STAT;
        #1;
        checks++;
        if (rdata !== 8'h48) begin failures++; $display("FAIL tx_full_status got=%h exp=48", rdata); end
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL tx_irq_busy got=%b exp=0", irq); end
        n = 0;
        while (rdata[6] === 1'b1 && n < 3000) begin
            @(negedge clk);
            #1 n++;
        end
        checks++;
        if (cyc - c0 !== 802) begin failures++; $display("FAIL tx_frames_len got=%0d exp=802", cyc - c0); end
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL tx_irq_early got=%b exp=0", irq); end
        @(negedge clk);
        #1;
        checks++;
        if (irq !== 1'b1 || rdata !== 8'h04) begin failures++; $display("FAIL tx_irq_rise irq=%b status=%h exp 1/04", irq, rdata); end
    endtask

    initial begin
        test_reset;
        test_tx_frame;
        test_reset_mid_frame;
        test_loopback;
        test_rx_overflow;
        test_frame_glitch;
        test_tx_full_irq;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_mmio_fifo.md
Name: uart_mmio_fifo

Overview:
Parametrised successor to the fixed UART-plus-IO pairing. It is a memory-mapped UART peripheral on the CPU byte bus, with TX and RX FIFOs, a programmable 16x-oversampling baud divisor, sticky error flags, loopback mode and a maskable interrupt. It sits beside io and ram behind the address decode, clocked on the CPU clock, and drives the board UART pins directly.

Parameters:
BASE_ADDR, 16'hE000, base of the 5-byte register window; must be 8-byte aligned.
DEPTH, 16, entries per FIFO; power of two, 2..256.
DIV_RESET, 27, baud divisor after reset (50 MHz / 115200 / 16).

Ports:
clk  in  1  CPU clock; all logic on the rising edge.
rst  in  1  synchronous, active-low reset.
addr  in  16  CPU byte address.
we  in  1  write strobe, one cycle.
re  in  1  read strobe, one cycle; used only for side effects (RX pop).
di  in  8  write data from CPU.
do  out  8  read data; combinational from addr; 8'h00 when sel=0.
sel  out  1  addr lies within BASE_ADDR..BASE_ADDR+4.
uart_rx  in  1  serial input, asynchronous, idle high.
uart_tx  out  1  serial output, idle high.
irq  out  1  level interrupt.

Behaviour:
Register map (offset from BASE_ADDR):
- 0 DATA
  - Write: push di into the TX FIFO. If the FIFO is full, the byte is dropped and TX FIFO state is unchanged.
  - Read: do = RX head, or 00 when the RX FIFO is empty. re pops one entry at the edge; re on an empty FIFO has no effect.
- 1 STATUS (read)
  - b0 rx_nempty, b1 rx_full, b2 tx_empty, b3 tx_full, b4 rx_ovf (sticky), b5 frame_err (sticky), b6 tx_busy, b7 = 0.
  - Writing 1 to b4 or b5 clears that flag; other bits ignore writes.
- 2 DIV_LO, 3 DIV_HI: 16-bit divisor, read/write. A divisor of 0 behaves as 1.
- 4 CTRL: b0 rx irq enable, b1 tx-empty irq enable, b2 loopback; b7..3 read 0.
- Unmapped offsets within the window: reads return 00, writes are ignored.

Reset (rst=0 at an edge):
- uart_tx = 1; both FIFOs empty; sticky flags = 0; CTRL = 0; divisor = DIV_RESET; TX/RX FSMs to IDLE; baud counter = 0.
- Reset mid-frame aborts the frame immediately.

Baud tick:
- Counter runs 0..div-1; tick16 pulses for one clk when count = div-1, then the counter returns to 0.
- Writing DIV_LO or DIV_HI reloads the counter to 0.

FIFO:
- Simultaneous push and pop on a full or empty FIFO both take effect; count is unchanged (an empty FIFO with push+pop stays empty and outputs nothing).
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH; count is log2(DEPTH)+1 bits.

TX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
- IDLE: if the TX FIFO is non-empty, pop into the shifter and go to START.
- START drives 0 for 16 ticks; DATA sends 8 bits LSB first, 16 ticks each; STOP drives 1 for 16 ticks.
- Back-to-back frames: a pending byte leaves STOP straight into the next START with no idle gap.
- tx_busy = state != IDLE.

RX FSM: IDLE -> START -> DATA -> STOP.
- Input path: 2-flop synchroniser on rx_in, where rx_in = loopback ? uart_tx : uart_rx.
- IDLE: on a synchronised 1->0 go to START and reset the tick count.
- START: at 8 ticks, sample. If the sample is 1, treat it as a glitch and return to IDLE. Otherwise sample every 16 ticks: 8 data bits LSB first, then stop.
- Stop = 1: push the byte. If the RX FIFO is full, drop the byte and set rx_ovf.
- Stop = 0: set frame_err, discard the byte, and wait for line = 1 before returning to IDLE.

Interrupt and loopback:
- irq = (CTRL.b0 & rx_nempty) | (CTRL.b1 & tx_empty & ~tx_busy); registered, one-cycle latency.
- In loopback, uart_tx still toggles on the pin.

Decomposition:
- Shared package uart_pkg: register offsets (DATA, STATUS, DIV_LO, DIV_HI, CTRL), STATUS/CTRL bit positions, TX/RX state encodings.
- One sub-module sync_fifo (parameter DEPTH, 8-bit data; ports push, pop, din, dout, full, empty), instantiated twice.
- Baud generator and both FSMs stay in the top module.

Test Plan:
- Reset: rst=0 for 2 cycles -> uart_tx=1, STATUS=8'h04, DIV_LO/HI=27/0, irq=0, do=00 at DATA.
- TX frame: DIV=1, write DATA=8'hA5 -> uart_tx low for 16 clks, then bits 1,0,1,0,0,1,0,1 at 16 clks each, then high 16; tx_busy high throughout; total 160 clks.
- Loopback burst: CTRL=04, write 3 bytes 11,22,33 -> after 3 frames STATUS.b0=1; reads return 11,22,33; then STATUS.b0=0; frames back-to-back with no idle gap.
- RX overflow: DEPTH=4, drive 5 external frames without reading -> rx_full=1, rx_ovf=1, reads return the first 4 bytes; write 8'h10 to STATUS -> rx_ovf=0.
- Framing/glitch: frame with stop=0 -> frame_err=1, RX FIFO empty. 3-clk low glitch at DIV=1 -> no byte pushed, no error.
- TX full and irq: write DEPTH+2 bytes while idle (one is taken by the shifter immediately) -> exactly DEPTH+1 bytes are transmitted; the last write is dropped. CTRL=02 -> irq rises 1 cycle after the final STOP ends.
